// File: rtl/quad_pkg.sv
// Shared constants, state encoding and input bundle for the quad motor mixer.
// Imported by pd_motor_mixer and motor_sat.
package quad_pkg;

  localparam int SPD_W = 11;
  localparam int SUM_W = 14;
  localparam int THR_W = 9;
  localparam int PT_W  = 10;
  localparam int DT_W  = 12;

  localparam logic [SPD_W-1:0] MIN_RUN   = 11'h2C0;
  localparam logic [SPD_W-1:0] CAL_SPEED = 11'h290;

  typedef enum logic [2:0] {
    IDLE,
    FRNT,
    BCK,
    LFT,
    RGHT
  } mix_state_t;

  typedef struct packed {
    logic        [THR_W-1:0] thrst;
    logic signed [PT_W-1:0]  ptch_p;
    logic signed [PT_W-1:0]  roll_p;
    logic signed [PT_W-1:0]  yaw_p;
    logic signed [DT_W-1:0]  ptch_d;
    logic signed [DT_W-1:0]  roll_d;
    logic signed [DT_W-1:0]  yaw_d;
  } bank_t;

  function automatic logic signed [SUM_W-1:0] sx_p(
    input logic [PT_W-1:0] v
  );
    return {{(SUM_W-PT_W){v[PT_W-1]}}, v};
  endfunction

  function automatic logic signed [SUM_W-1:0] sx_d(
    input logic [DT_W-1:0] v
  );
    return {{(SUM_W-DT_W){v[DT_W-1]}}, v};
  endfunction

endpackage

// File: rtl/motor_sat.sv
// Clips a signed mixer sum into the unsigned motor speed range.
// Negative sums floor at zero, large sums pin at full scale.
module motor_sat
  import quad_pkg::*;
(
  input  logic signed [SUM_W-1:0] sum,
  output logic        [SPD_W-1:0] spd
);

  localparam logic signed [SUM_W-1:0] SPD_MAX =
    SUM_W'((1 << SPD_W) - 1);

  always_comb begin
    spd = sum[SPD_W-1:0];
    if (sum[SUM_W-1])
      spd = '0;
    else if (sum > SPD_MAX)
      spd = '1;
  end

endmodule

// File: rtl/pd_motor_mixer.sv
// Time-multiplexed quad mixer: one shared adder/clip computes one motor
// per cycle, then all four speeds publish together on the RGHT edge.
module pd_motor_mixer
  import quad_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    vld,
  input  logic [THR_W-1:0]        thrst,
  input  logic signed [PT_W-1:0]  ptch_pterm,
  input  logic signed [PT_W-1:0]  roll_pterm,
  input  logic signed [PT_W-1:0]  yaw_pterm,
  input  logic signed [DT_W-1:0]  ptch_dterm,
  input  logic signed [DT_W-1:0]  roll_dterm,
  input  logic signed [DT_W-1:0]  yaw_dterm,
  input  logic                    inertial_cal,
  output logic [SPD_W-1:0]        frnt_spd,
  output logic [SPD_W-1:0]        bck_spd,
  output logic [SPD_W-1:0]        lft_spd,
  output logic [SPD_W-1:0]        rght_spd,
  output logic                    spd_vld,
  output logic                    busy
);

  mix_state_t state;
  bank_t      cur;
  bank_t      wrk;
  bank_t      shd;
  logic       pend;

  logic [SPD_W-1:0] frnt_stg;
  logic [SPD_W-1:0] bck_stg;
  logic [SPD_W-1:0] lft_stg;

  logic              use_ptch;
  logic              ax_neg;
  logic [PT_W-1:0]   ax_p;
  logic [DT_W-1:0]   ax_d;
  logic signed [SUM_W-1:0] base;
  logic signed [SUM_W-1:0] ax;
  logic signed [SUM_W-1:0] yw;
  logic signed [SUM_W-1:0] s1;
  logic signed [SUM_W-1:0] sum;
  logic [SPD_W-1:0]  clip;

  assign cur = '{
    thrst:  thrst,
    ptch_p: ptch_pterm,
    roll_p: roll_pterm,
    yaw_p:  yaw_pterm,
    ptch_d: ptch_dterm,
    roll_d: roll_dterm,
    yaw_d:  yaw_dterm
  };

  // Front/back use pitch and subtract yaw; left/right use roll, add yaw.
  always_comb begin
    use_ptch = (state == FRNT) || (state == BCK);
    ax_neg   = (state == BCK) || (state == RGHT);
    ax_p     = use_ptch ? wrk.ptch_p : wrk.roll_p;
    ax_d     = use_ptch ? wrk.ptch_d : wrk.roll_d;
    base     = SUM_W'(MIN_RUN) + SUM_W'(wrk.thrst);
    ax       = sx_p(ax_p) + sx_d(ax_d);
    yw       = sx_p(wrk.yaw_p) + sx_d(wrk.yaw_d);
    s1       = ax_neg ? (base - ax) : (base + ax);
    sum      = use_ptch ? (s1 - yw) : (s1 + yw);
  end

  motor_sat u_sat (
    .sum (sum),
    .spd (clip)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      wrk      <= '0;
      shd      <= '0;
      pend     <= 1'b0;
      frnt_stg <= '0;
      bck_stg  <= '0;
      lft_stg  <= '0;
      frnt_spd <= '0;
      bck_spd  <= '0;
      lft_spd  <= '0;
      rght_spd <= '0;
      spd_vld  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      spd_vld <= 1'b0;
      if (vld && (state == FRNT || state == BCK || state == LFT)) begin
        shd  <= cur;
        pend <= 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (vld) begin
            wrk   <= cur;
            state <= FRNT;
            busy  <= 1'b1;
          end
        end
        FRNT: begin
          frnt_stg <= clip;
          state    <= BCK;
        end
        BCK: begin
          bck_stg <= clip;
          state   <= LFT;
        end
        LFT: begin
          lft_stg <= clip;
          state   <= RGHT;
        end
        RGHT: begin
          frnt_spd <= inertial_cal ? CAL_SPEED : frnt_stg;
          bck_spd  <= inertial_cal ? CAL_SPEED : bck_stg;
          lft_spd  <= inertial_cal ? CAL_SPEED : lft_stg;
          rght_spd <= inertial_cal ? CAL_SPEED : clip;
          spd_vld  <= 1'b1;
          if (vld || pend) begin
            wrk   <= vld ? cur : shd;
            pend  <= 1'b0;
            state <= FRNT;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pd_motor_mixer.sv
// Directed and randomized checks of pd_motor_mixer against an
// arithmetic reference of the mixing equations.
module tb_pd_motor_mixer;

  logic        clk = 1'b0;
  logic        rst;
  logic        vld;
  logic [8:0]  thrst;
  logic [9:0]  ptch_pterm, roll_pterm, yaw_pterm;
  logic [11:0] ptch_dterm, roll_dterm, yaw_dterm;
  logic        inertial_cal;
  logic [10:0] frnt_spd, bck_spd, lft_spd, rght_spd;
  logic        spd_vld;
  logic        busy;

  int tests = 0;
  int fails = 0;
  int e_f, e_b, e_l, e_r;

  pd_motor_mixer dut (
    .clk          (clk),
    .rst          (rst),
    .vld          (vld),
    .thrst        (thrst),
    .ptch_pterm   (ptch_pterm),
    .roll_pterm   (roll_pterm),
    .yaw_pterm    (yaw_pterm),
    .ptch_dterm   (ptch_dterm),
    .roll_dterm   (roll_dterm),
    .yaw_dterm    (yaw_dterm),
    .inertial_cal (inertial_cal),
    .frnt_spd     (frnt_spd),
    .bck_spd      (bck_spd),
    .lft_spd      (lft_spd),
    .rght_spd     (rght_spd),
    .spd_vld      (spd_vld),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [10:0] obs,
                     input logic [10:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int clip(input int v);
    if (v < 0) return 0;
    if (v > 2047) return 2047;
    return v;
  endfunction

  task automatic model(input int t, input int pp, input int pd,
                       input int rp, input int rd, input int yp,
                       input int yd, input bit cal);
    int p, r, y, base;
    p = pp + pd;
    r = rp + rd;
    y = yp + yd;
    base = 704 + t;
    e_f = clip(base + p - y);
    e_b = clip(base - p - y);
    e_l = clip(base + r + y);
    e_r = clip(base - r + y);
    if (cal) begin
      e_f = 656; e_b = 656; e_l = 656; e_r = 656;
    end
  endtask

  task automatic drive(input int t, input int pp, input int pd,
                       input int rp, input int rd, input int yp,
                       input int yd);
    thrst      = 9'(t);
    ptch_pterm = 10'(pp);
    ptch_dterm = 12'(pd);
    roll_pterm = 10'(rp);
    roll_dterm = 12'(rd);
    yaw_pterm  = 10'(yp);
    yaw_dterm  = 12'(yd);
  endtask

  task automatic scramble();
    drive($urandom_range(0, 511), $urandom_range(0, 1023) - 512,
          $urandom_range(0, 4095) - 2048, $urandom_range(0, 1023) - 512,
          $urandom_range(0, 4095) - 2048, $urandom_range(0, 1023) - 512,
          $urandom_range(0, 4095) - 2048);
  endtask

  task automatic chk_spd(input string tag);
    chk({tag, ".frnt"}, frnt_spd, 11'(e_f));
    chk({tag, ".bck"},  bck_spd,  11'(e_b));
    chk({tag, ".lft"},  lft_spd,  11'(e_l));
    chk({tag, ".rght"}, rght_spd, 11'(e_r));
  endtask

  // Called at a negedge; returns at the negedge after the hold check.
  task automatic run_one(input string tag, input int t, input int pp,
                         input int pd, input int rp, input int rd,
                         input int yp, input int yd, input bit cal);
    drive(t, pp, pd, rp, rd, yp, yd);
    inertial_cal = cal;
    vld = 1'b1;
    model(t, pp, pd, rp, rd, yp, yd, cal);
    @(negedge clk);
    vld = 1'b0;
    scramble();
    for (int i = 0; i < 4; i++) begin
      chk({tag, ".busy"}, 11'(busy), 11'd1);
      chk({tag, ".early_vld"}, 11'(spd_vld), 11'd0);
      @(negedge clk);
    end
    chk({tag, ".spd_vld"}, 11'(spd_vld), 11'd1);
    chk({tag, ".busy_off"}, 11'(busy), 11'd0);
    chk_spd(tag);
    inertial_cal = 1'b0;
    @(negedge clk);
    chk({tag, ".vld_pulse"}, 11'(spd_vld), 11'd0);
    chk_spd({tag, ".hold"});
  endtask

  initial begin
    int dt, dpp, dpd, drp, drd, dyp, dyd;
    rst = 1'b1;
    vld = 1'b0;
    inertial_cal = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("reset.frnt", frnt_spd, 11'd0);
    chk("reset.rght", rght_spd, 11'd0);
    chk("reset.spd_vld", 11'(spd_vld), 11'd0);
    chk("reset.busy", 11'(busy), 11'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_one("zero", 0, 0, 0, 0, 0, 0, 0, 1'b0);
    chk("zero.const", frnt_spd, 11'h2C0);
    run_one("pitch", 100, 50, 20, 0, 0, 0, 0, 1'b0);
    chk("pitch.const", frnt_spd, 11'h36A);
    run_one("sat", 511, 511, 2047, 0, 0, 0, 0, 1'b0);
    chk("sat.const", lft_spd, 11'h4BF);
    run_one("cal", 300, 100, -200, 30, 40, -50, 60, 1'b1);
    run_one("neg_ext", 0, -512, -2048, -512, -2048, -512, -2048, 1'b0);
    run_one("pos_ext", 511, 511, 2047, 511, 2047, 511, 2047, 1'b0);

    // Three strobes during one computation: the last one wins.
    drive(10, 20, 30, -40, 50, 60, -70);
    vld = 1'b1;
    @(negedge clk);
    model(10, 20, 30, -40, 50, 60, -70, 1'b0);
    for (int k = 0; k < 3; k++) begin
      dt = $urandom_range(0, 511);
      dpp = $urandom_range(0, 1023) - 512;
      dpd = $urandom_range(0, 4095) - 2048;
      drp = $urandom_range(0, 1023) - 512;
      drd = $urandom_range(0, 4095) - 2048;
      dyp = $urandom_range(0, 1023) - 512;
      dyd = $urandom_range(0, 4095) - 2048;
      drive(dt, dpp, dpd, drp, drd, dyp, dyd);
      @(negedge clk);
    end
    vld = 1'b0;
    scramble();
    @(negedge clk);
    chk("multi.first_vld", 11'(spd_vld), 11'd1);
    chk_spd("multi.first");
    model(dt, dpp, dpd, drp, drd, dyp, dyd, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("multi.gap_vld", 11'(spd_vld), 11'd0);
      chk("multi.gap_busy", 11'(busy), 11'd1);
    end
    @(negedge clk);
    chk("multi.second_vld", 11'(spd_vld), 11'd1);
    chk_spd("multi.second");
    @(negedge clk);
    chk("multi.idle", 11'(busy), 11'd0);

    // Reset while the FSM sits in BCK.
    run_one("pre_rst", 200, 10, 10, 10, 10, 10, 10, 1'b0);
    drive(50, 1, 2, 3, 4, 5, 6);
    vld = 1'b1;
    @(negedge clk);
    vld = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid.frnt", frnt_spd, 11'd0);
    chk("rst_mid.bck", bck_spd, 11'd0);
    chk("rst_mid.lft", lft_spd, 11'd0);
    chk("rst_mid.rght", rght_spd, 11'd0);
    chk("rst_mid.busy", 11'(busy), 11'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("rst_mid.no_vld", 11'(spd_vld), 11'd0);
      chk("rst_mid.idle", 11'(busy), 11'd0);
    end
    run_one("post_rst", 123, -45, 67, 89, -101, 23, -45, 1'b0);

    for (int n = 0; n < 15; n++) begin
      run_one("rand", $urandom_range(0, 511),
              $urandom_range(0, 1023) - 512,
              $urandom_range(0, 4095) - 2048,
              $urandom_range(0, 1023) - 512,
              $urandom_range(0, 4095) - 2048,
              $urandom_range(0, 1023) - 512,
              $urandom_range(0, 4095) - 2048,
              ($urandom_range(0, 3) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
